qk_inst_sequencer: RTL



---
 rtl/qk_inst_sequencer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/qk_inst_sequencer.sv
// Instruction sequencer for fullchip: collects Q/K vectors, then issues load/execute/drain/readout.
// Optional pmem readout phase is built only when SEQ_READBACK_EN is defined.
module qk_inst_sequencer #(
   parameter int unsigned bw     = 8,
   parameter int unsigned pr     = 8,
   parameter int unsigned col    = 8,
   parameter int unsigned addr_w = 4,
   parameter int unsigned gap    = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [addr_w:0]     n_q,
   input  logic [pr*bw-1:0]    vec_in,
   input  logic                vec_valid,
   output logic                vec_ready,
   output logic [16:0]         inst,
   output logic [pr*bw-1:0]    mem_in,
   output logic                busy,
   output logic                out_valid,
   output logic                done
);

   localparam int unsigned vec_w     = pr * bw;
   localparam int unsigned nq_w      = addr_w + 1;
   localparam int unsigned q_depth   = 1 << addr_w;
   localparam int unsigned cnt_max_a = (q_depth > col + 2) ? q_depth : col + 2;
   localparam int unsigned cnt_max   = (cnt_max_a > gap) ? cnt_max_a : gap;
   localparam int unsigned cnt_w     = $clog2(cnt_max + 1);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_QWR   = 4'd1;
   localparam logic [3:0] S_KWR   = 4'd2;
   localparam logic [3:0] S_GAP_A = 4'd3;
   localparam logic [3:0] S_KLOAD = 4'd4;
   localparam logic [3:0] S_GAP_B = 4'd5;
   localparam logic [3:0] S_EXEC  = 4'd6;
   localparam logic [3:0] S_GAP_C = 4'd7;
   localparam logic [3:0] S_DRAIN = 4'd8;
   localparam logic [3:0] S_DONE  = 4'd10;
`ifdef SEQ_READBACK_EN
   localparam logic [3:0] S_READ  = 4'd9;
   localparam logic [3:0] after_drain = S_READ;
`else
   localparam logic [3:0] after_drain = S_DONE;
`endif

   // A zero gap removes the idle state entirely
   localparam logic [3:0] after_kwr   = (gap == 0) ? S_KLOAD : S_GAP_A;
   localparam logic [3:0] after_kload = (gap == 0) ? S_EXEC  : S_GAP_B;
   localparam logic [3:0] after_exec  = (gap == 0) ? S_DRAIN : S_GAP_C;

   typedef struct packed {
      logic       ofifo_rd;
      logic [3:0] qkmem_add;
      logic [3:0] pmem_add;
      logic       execute;
      logic       load;
      logic       qmem_rd;
      logic       qmem_wr;
      logic       kmem_rd;
      logic       kmem_wr;
      logic       pmem_rd;
      logic       pmem_wr;
   } inst_t;

   logic [3:0]       state_q, state_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic [nq_w-1:0]  neff_q, neff_d;
   inst_t            inst_q, inst_d;
   logic [vec_w-1:0] mem_in_q, mem_in_d;
   logic             vec_ready_q, busy_q, done_q;
   logic             hs, last_q, last_col, last_gap, last_kload;

   assign hs         = vec_valid & vec_ready_q;
   assign last_q     = (cnt_q == cnt_w'(neff_q) - cnt_w'(1));
   assign last_col   = (cnt_q == cnt_w'(col) - cnt_w'(1));
   assign last_gap   = (cnt_q == cnt_w'(gap) - cnt_w'(1));
   assign last_kload = (cnt_q == cnt_w'(col) + cnt_w'(1));

   // Next state plus the instruction word to present on the following cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      neff_d   = neff_q;
      inst_d   = '0;
      mem_in_d = '0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               if (n_q > nq_w'(q_depth)) neff_d = nq_w'(q_depth);
               else                      neff_d = n_q;
               state_d = (n_q == '0) ? S_DONE : S_QWR;
            end
         end
         S_QWR: begin
            if (hs) begin
               inst_d.qmem_wr   = 1'b1;
               inst_d.qkmem_add = 4'(cnt_q);
               mem_in_d         = vec_in;
               if (last_q) begin
                  cnt_d   = '0;
                  state_d = S_KWR;
               end else begin
                  cnt_d = cnt_q + cnt_w'(1);
               end
            end
         end
         S_KWR: begin
            if (hs) begin
               inst_d.kmem_wr   = 1'b1;
               inst_d.qkmem_add = 4'(cnt_q);
               mem_in_d         = vec_in;
               if (last_col) begin
                  cnt_d   = '0;
                  state_d = after_kwr;
               end else begin
                  cnt_d = cnt_q + cnt_w'(1);
               end
            end
         end
         S_GAP_A, S_GAP_B, S_GAP_C: begin
            if (last_gap) begin
               cnt_d = '0;
               if (state_q == S_GAP_A)      state_d = S_KLOAD;
               else if (state_q == S_GAP_B) state_d = S_EXEC;
               else                         state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + cnt_w'(1);
            end
         end
         S_KLOAD: begin
            inst_d.load = 1'b1;
            if (cnt_q != '0 && cnt_q <= cnt_w'(col)) begin
               inst_d.kmem_rd   = 1'b1;
               inst_d.qkmem_add = 4'(cnt_q - cnt_w'(1));
            end
            if (last_kload) begin
               cnt_d   = '0;
               state_d = after_kload;
            end else begin
               cnt_d = cnt_q + cnt_w'(1);
            end
         end
         S_EXEC: begin
            inst_d.execute   = 1'b1;
            inst_d.qmem_rd   = 1'b1;
            inst_d.qkmem_add = 4'(cnt_q);
            if (last_q) begin
               cnt_d   = '0;
               state_d = after_exec;
            end else begin
               cnt_d = cnt_q + cnt_w'(1);
            end
         end
         S_DRAIN: begin
            inst_d.ofifo_rd = 1'b1;
            inst_d.pmem_wr  = 1'b1;
            inst_d.pmem_add = 4'(cnt_q);
            if (last_q) begin
               cnt_d   = '0;
               state_d = after_drain;
            end else begin
               cnt_d = cnt_q + cnt_w'(1);
            end
         end
`ifdef SEQ_READBACK_EN
         S_READ: begin
            inst_d.pmem_rd  = 1'b1;
            inst_d.pmem_add = 4'(cnt_q);
            if (last_q) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + cnt_w'(1);
            end
         end
`endif
         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Status flags follow the next state so they line up with the state they describe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         neff_q      <= '0;
         inst_q      <= '0;
         mem_in_q    <= '0;
         vec_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         neff_q      <= neff_d;
         inst_q      <= inst_d;
         mem_in_q    <= mem_in_d;
         vec_ready_q <= (state_d == S_QWR) || (state_d == S_KWR);
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_DONE);
      end
   end

`ifdef SEQ_READBACK_EN
   logic out_valid_q;

   // pmem has one cycle of read latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_valid_q <= 1'b0;
      else          out_valid_q <= inst_q.pmem_rd;
   end

   assign out_valid = out_valid_q;
`else
   assign out_valid = 1'b0;
`endif

   assign inst      = inst_q;
   assign mem_in    = mem_in_q;
   assign vec_ready = vec_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
